// File: rtl/ptc_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ptc_power_sequencer
// Description : Brings up the PTC LV rails, boots the XMC4300 through PORST_N,
//               staggers the six VP12 channels on and off, and latches a
//               fault from the filtered LTC2645 alerts that drops every rail.
// Revision    : 1.0 - initial release
// ============================================================================
module ptc_power_sequencer #(
  parameter int SETTLE_CYCLES  = 100000,
  parameter int XMC_RST_CYCLES = 10000,
  parameter int STAGGER_CYCLES = 50000,
  parameter int ALERT_FILT     = 16
) (
  input  logic       i_clk_axi,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [5:0] i_vp12_mask,
  input  logic [1:0] i_lv_alert_n,
  input  logic [5:0] i_vp12_alert_n,
  input  logic       i_fault_clr,
  output logic       o_en_lv,
  output logic [5:0] o_vp12_en,
  output logic       o_xmc_jtag_en,
  output logic       o_xmc_reset_n,
  output logic       o_ready,
  output logic       o_fault,
  output logic [7:0] o_fault_src,
  output logic [2:0] o_state
);

  localparam int C_MAX_A = (SETTLE_CYCLES > XMC_RST_CYCLES) ? SETTLE_CYCLES : XMC_RST_CYCLES;
  localparam int C_MAX   = (C_MAX_A > STAGGER_CYCLES) ? C_MAX_A : STAGGER_CYCLES;
  localparam int CW      = $clog2(C_MAX + 1);
  localparam int FW      = $clog2(ALERT_FILT + 1);

  // Timers hold "cycles remaining - 1", so a load of 0 costs exactly one cycle.
  localparam logic [CW-1:0] C_SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] C_XMC_LD    = CW'(XMC_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_STAG_LD   = CW'(STAGGER_CYCLES - 1);
  localparam logic [FW-1:0] C_FILT_MAX  = FW'(ALERT_FILT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LV_RAMP   = 3'd1,
    S_XMC_BOOT  = 3'd2,
    S_VP12_RAMP = 3'd3,
    S_ON        = 3'd4,
    S_DOWN      = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [5:0]      r_mask;
  logic            r_en_lv;
  logic [5:0]      r_vp12_en;
  logic            r_jtag_en;
  logic            r_xrst_n;
  logic            r_ready;
  logic            r_fault;
  logic [7:0]      r_fault_src;
  logic [FW-1:0]   r_filt_cnt [8];

  logic [7:0]      w_alert_n;
  logic [7:0]      w_filt;
  logic            w_lv_win;
  logic            w_active;
  logic [7:0]      w_fault_vec;
  logic            w_fault_hit;
  logic [2:0]      w_idx_up;
  logic [2:0]      w_idx_dn;

  // Bit order matches fault_src: {vp12[5:0], 3v3, 2v5}.
  assign w_alert_n = {i_vp12_alert_n, i_lv_alert_n};

  // Per-alert low-run counter: clears on any high sample, saturates at the threshold.
  always_ff @(posedge i_clk_axi) begin
    for (int i = 0; i < 8; i++) begin
      if (i_rst || w_alert_n[i]) begin
        r_filt_cnt[i] <= '0;
      end else if (r_filt_cnt[i] != C_FILT_MAX) begin
        r_filt_cnt[i] <= r_filt_cnt[i] + 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < 8; g++) begin : g_filt
      assign w_filt[g] = (r_filt_cnt[g] == C_FILT_MAX);
    end
  endgenerate

  // LV alerts are ignored while the rails are still ramping.
  assign w_lv_win    = (r_state == S_XMC_BOOT) || (r_state == S_VP12_RAMP) ||
                       (r_state == S_ON)       || (r_state == S_DOWN);
  assign w_active    = w_lv_win || (r_state == S_LV_RAMP);
  assign w_fault_vec = w_filt & {r_vp12_en, w_lv_win, w_lv_win};
  assign w_fault_hit = w_active && (|w_fault_vec);
  assign w_idx_up    = r_idx + 3'd1;
  assign w_idx_dn    = r_idx - 3'd1;

  // Sequencer: fault beats stop, stop beats timer expiry.
  always_ff @(posedge i_clk_axi) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_mask      <= '0;
      r_en_lv     <= 1'b0;
      r_vp12_en   <= '0;
      r_jtag_en   <= 1'b0;
      r_xrst_n    <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_fault_src <= '0;
    end else if (w_fault_hit) begin
      r_state     <= S_FAULT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_en_lv     <= 1'b0;
      r_vp12_en   <= '0;
      r_jtag_en   <= 1'b0;
      r_xrst_n    <= 1'b0;
      r_ready     <= 1'b0;
      r_fault     <= 1'b1;
      r_fault_src <= w_fault_vec;
    end else if (i_stop && (w_active && r_state != S_DOWN)) begin
      // Power-down walks from channel 5; only channels already on cost a full gap.
      r_state      <= S_DOWN;
      r_idx        <= 3'd5;
      r_vp12_en[5] <= 1'b0;
      r_cnt        <= r_vp12_en[5] ? C_STAG_LD : '0;
      r_ready      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_state <= S_LV_RAMP;
            r_mask  <= i_vp12_mask;
            r_en_lv <= 1'b1;
            r_cnt   <= C_SETTLE_LD;
          end
        end
        S_LV_RAMP: begin
          if (r_cnt == '0) begin
            r_state   <= S_XMC_BOOT;
            r_jtag_en <= 1'b1;
            r_xrst_n  <= 1'b0;
            r_cnt     <= C_XMC_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_XMC_BOOT: begin
          if (r_cnt == '0) begin
            r_state      <= S_VP12_RAMP;
            r_xrst_n     <= 1'b1;
            r_idx        <= 3'd0;
            r_vp12_en[0] <= r_mask[0];
            r_cnt        <= r_mask[0] ? C_STAG_LD : '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_VP12_RAMP: begin
          if (r_cnt == '0) begin
            if (r_idx == 3'd5) begin
              r_state <= S_ON;
              r_ready <= 1'b1;
            end else begin
              r_idx               <= w_idx_up;
              r_vp12_en[w_idx_up] <= r_mask[w_idx_up];
              r_cnt               <= r_mask[w_idx_up] ? C_STAG_LD : '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ON: begin
          r_ready <= 1'b1;
        end
        S_DOWN: begin
          if (r_cnt == '0) begin
            if (r_idx == 3'd0) begin
              r_state   <= S_IDLE;
              r_en_lv   <= 1'b0;
              r_jtag_en <= 1'b0;
              r_xrst_n  <= 1'b0;
              r_vp12_en <= '0;
            end else begin
              r_idx               <= w_idx_dn;
              r_vp12_en[w_idx_dn] <= 1'b0;
              r_cnt               <= r_vp12_en[w_idx_dn] ? C_STAG_LD : '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FAULT: begin
          if (i_fault_clr && (&w_alert_n)) begin
            r_state     <= S_IDLE;
            r_fault     <= 1'b0;
            r_fault_src <= '0;
          end
        end
        default: begin
          r_state     <= S_FAULT;
          r_cnt       <= '0;
          r_idx       <= '0;
          r_en_lv     <= 1'b0;
          r_vp12_en   <= '0;
          r_jtag_en   <= 1'b0;
          r_xrst_n    <= 1'b0;
          r_ready     <= 1'b0;
          r_fault     <= 1'b1;
          r_fault_src <= '0;
        end
      endcase
    end
  end

  assign o_en_lv       = r_en_lv;
  assign o_vp12_en     = r_vp12_en;
  assign o_xmc_jtag_en = r_jtag_en;
  assign o_xmc_reset_n = r_xrst_n;
  assign o_ready       = r_ready;
  assign o_fault       = r_fault;
  assign o_fault_src   = r_fault_src;
  assign o_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ptc_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptc_power_sequencer
// Description : Directed scoreboard bench for ptc_power_sequencer. Stimulus
//               pushes the expected output bundle and the cycle it must appear
//               on; a monitor pops an entry on every output change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptc_power_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [5:0] vp12_mask = 6'h00;
  logic [1:0] lv_alert_n = 2'b11;
  logic [5:0] vp12_alert_n = 6'h3F;
  logic       fault_clr = 1'b0;
  logic       en_lv, jtag_en, xrst_n, ready, fault;
  logic [5:0] vp12_en;
  logic [7:0] fault_src;
  logic [2:0] state;

  ptc_power_sequencer #(
    .SETTLE_CYCLES (8),
    .XMC_RST_CYCLES(3),
    .STAGGER_CYCLES(4),
    .ALERT_FILT    (2)
  ) dut (
    .i_clk_axi     (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_stop        (stop),
    .i_vp12_mask   (vp12_mask),
    .i_lv_alert_n  (lv_alert_n),
    .i_vp12_alert_n(vp12_alert_n),
    .i_fault_clr   (fault_clr),
    .o_en_lv       (en_lv),
    .o_vp12_en     (vp12_en),
    .o_xmc_jtag_en (jtag_en),
    .o_xmc_reset_n (xrst_n),
    .o_ready       (ready),
    .o_fault       (fault),
    .o_fault_src   (fault_src),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [21:0] b;
    string       nm;
  } ev_t;

  ev_t  q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;
  logic [21:0] w_bundle;

  assign w_bundle = {state, en_lv, vp12_en, jtag_en, xrst_n, ready, fault, fault_src};

  function automatic logic [21:0] mk(input logic [2:0] st, input logic lv, input logic [5:0] vp,
                                     input logic jt, input logic rn, input logic rdy,
                                     input logic flt, input logic [7:0] src);
    return {st, lv, vp, jt, rn, rdy, flt, src};
  endfunction

  task automatic exp(input int c, input logic [21:0] b, input string nm);
    q.push_back('{c, b, nm});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every output change must match the next queued event and its cycle.
  initial begin
    logic [21:0] prev;
    logic [21:0] cur;
    ev_t         ev;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = w_bundle;
      if (mon_on) begin
        if (cur !== prev) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change cyc=%0d actual=%h required=no change", cyc, cur);
          end else begin
            ev = q.pop_front();
            if (ev.c != cyc || ev.b !== cur) begin
              n_bad++;
              $display("FAIL %s actual=%h@%0d required=%h@%0d", ev.nm, cur, cyc, ev.b, ev.c);
            end
          end
        end else if (q.size() > 0 && q[0].c < cyc) begin
          ev = q.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL %s actual=%h (no change)@%0d required=%h@%0d", ev.nm, cur, cyc, ev.b, ev.c);
        end
      end
      prev = cur;
    end
  end

  // Start pulse; queues LV_RAMP, XMC_BOOT and (if n_ev>2) the VP12_RAMP entry.
  task automatic start_seq(input logic [5:0] m, input int n_ev, output int t);
    t         = cyc;
    start     = 1'b1;
    vp12_mask = m;
    exp(t + 1, mk(3'd1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), "lv_ramp_entry");
    if (n_ev > 1) exp(t + 9, mk(3'd2, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), "xmc_boot_entry");
    if (n_ev > 2) exp(t + 12, mk(3'd3, 1'b1, {5'b0, m[0]}, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "vp12_ramp_entry");
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic full_powerup();
    int t;
    logic [5:0] v;
    start_seq(6'h3F, 3, t);
    v = 6'h01;
    for (int k = 1; k < 6; k++) begin
      v = {v[4:0], 1'b1};
      exp(t + 12 + 4 * k, mk(3'd3, 1'b1, v, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "vp12_stagger_on");
    end
    exp(t + 36, mk(3'd4, 1'b1, 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00), "ready_full");
    wait_to(t + 40);
  endtask

  initial begin
    int t;
    logic [5:0] v;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (w_bundle !== 22'h0) begin
      n_bad++;
      $display("FAIL reset_state actual=%h required=%h", w_bundle, 22'h0);
    end
    mon_on = 1'b1;
    @(negedge clk);

    // Full power-up, then orderly stop
    full_powerup();
    t    = cyc;
    stop = 1'b1;
    exp(t + 1, mk(3'd5, 1'b1, 6'h1F, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "down_entry");
    v = 6'h1F;
    for (int k = 1; k < 6; k++) begin
      v = v >> 1;
      exp(t + 1 + 4 * k, mk(3'd5, 1'b1, v, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "vp12_stagger_off");
    end
    exp(t + 25, 22'h0, "down_to_idle");
    @(negedge clk);
    stop = 1'b0;
    wait_to(t + 30);

    // Alert filter: 1-cycle glitch ignored, sustained low faults, clear waits for release
    full_powerup();
    vp12_alert_n[2] = 1'b0;
    @(negedge clk);
    vp12_alert_n[2] = 1'b1;
    repeat (4) @(negedge clk);
    t = cyc;
    vp12_alert_n[2] = 1'b0;
    exp(t + 3, mk(3'd6, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10), "vp12_alert_fault");
    wait_to(t + 5);
    fault_clr = 1'b1;
    wait_to(t + 8);
    exp(t + 9, 22'h0, "fault_clr_to_idle");
    vp12_alert_n[2] = 1'b1;
    wait_to(t + 10);
    fault_clr = 1'b0;
    wait_to(t + 13);

    // Sparse mask, then orderly stop skipping the off channels
    start_seq(6'b100001, 3, t);
    exp(t + 20, mk(3'd3, 1'b1, 6'h21, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "sparse_ch5_on");
    exp(t + 24, mk(3'd4, 1'b1, 6'h21, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00), "sparse_ready");
    wait_to(t + 28);
    t    = cyc;
    stop = 1'b1;
    exp(t + 1, mk(3'd5, 1'b1, 6'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "sparse_down_entry");
    exp(t + 9, mk(3'd5, 1'b1, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "sparse_ch0_off");
    exp(t + 13, 22'h0, "sparse_down_idle");
    @(negedge clk);
    stop = 1'b0;
    wait_to(t + 17);

    // Stop mid-ramp with start held; start+stop in IDLE stays IDLE
    start_seq(6'h3F, 3, t);
    exp(t + 16, mk(3'd3, 1'b1, 6'h03, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "midramp_ch1_on");
    wait_to(t + 17);
    stop  = 1'b1;
    start = 1'b1;
    exp(t + 18, mk(3'd5, 1'b1, 6'h03, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "midramp_down_entry");
    exp(t + 22, mk(3'd5, 1'b1, 6'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "midramp_ch1_off");
    exp(t + 26, mk(3'd5, 1'b1, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00), "midramp_ch0_off");
    exp(t + 30, 22'h0, "midramp_idle");
    wait_to(t + 34);
    start = 1'b0;
    stop  = 1'b0;
    wait_to(t + 37);

    // Reset in VP12_RAMP
    start_seq(6'h3F, 3, t);
    wait_to(t + 13);
    rst = 1'b1;
    exp(t + 14, 22'h0, "reset_midramp");
    @(negedge clk);
    rst = 1'b0;
    wait_to(t + 18);

    // LV alert masked in LV_RAMP, faults once XMC_BOOT is reached
    start_seq(6'h3F, 2, t);
    wait_to(t + 2);
    lv_alert_n[1] = 1'b0;
    exp(t + 10, mk(3'd6, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02), "lv_alert_fault");
    wait_to(t + 11);
    lv_alert_n = 2'b11;
    fault_clr  = 1'b1;
    exp(t + 12, 22'h0, "lv_fault_clr");
    wait_to(t + 13);
    fault_clr = 1'b0;
    wait_to(t + 18);

    while (q.size() > 0) begin
      ev_t ev;
      ev = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s actual=never seen required=%h@%0d", ev.nm, ev.b, ev.c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
